// File: rtl/data_tag_array.sv
// Set-associative tag/valid/dirty store: port 0 refill/writeback, port 1 registered hit lookup, invalidation sweep.
// Optional DATA_TAG_PARITY_EN: a parity bit protects each way's tag/valid/dirty, and parity_error_o is added.
module data_tag_array #(
    parameter  int TAG_SIZE   = 20,
    parameter  int INDEX_SIZE = 7,
    parameter  int WAYS       = 2,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  busy_o,
`ifdef DATA_TAG_PARITY_EN
    output logic                  parity_error_o,
`endif
    input  logic [INDEX_SIZE-1:0] port0_index_i,
    input  logic [WAY_W-1:0]      port0_way_i,
    input  logic [TAG_SIZE-1:0]   port0_tag_i,
    input  logic                  port0_valid_i,
    input  logic                  port0_dirty_i,
    input  logic                  port0_write_i,
    input  logic                  port0_read_i,
    output logic [TAG_SIZE-1:0]   port0_tag_o,
    output logic                  port0_valid_o,
    output logic                  port0_dirty_o,
    input  logic [INDEX_SIZE-1:0] port1_index_i,
    input  logic [TAG_SIZE-1:0]   port1_tag_i,
    input  logic                  port1_read_i,
    output logic                  port1_hit_o,
    output logic [WAY_W-1:0]      port1_hit_way_o,
    output logic                  port1_dirty_o
);
    localparam int DEPTH = 2**INDEX_SIZE;

    // The tag and the status bits live in separate RAMs per way so the sweep can clear
    // valid/dirty without touching the tag; with parity, each field carries its own bit.
`ifdef DATA_TAG_PARITY_EN
    localparam int PW = 1;
    function automatic logic [TAG_SIZE:0] pack_tag(input logic [TAG_SIZE-1:0] t);
        return {^t, t};
    endfunction
    function automatic logic [2:0] pack_stat(input logic v, input logic d);
        return {v ^ d, v, d};
    endfunction
`else
    localparam int PW = 0;
    function automatic logic [TAG_SIZE-1:0] pack_tag(input logic [TAG_SIZE-1:0] t);
        return t;
    endfunction
    function automatic logic [1:0] pack_stat(input logic v, input logic d);
        return {v, d};
    endfunction
`endif
    localparam int TW = TAG_SIZE + PW;
    localparam int SW = 2 + PW;

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t                state;
    logic [INDEX_SIZE-1:0] sweep_cnt;
    logic                  idle;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            busy_o    <= 1'b1;
        end else begin
            case (state)
                SWEEP: begin
                    sweep_cnt <= sweep_cnt + INDEX_SIZE'(1);
                    if (&sweep_cnt) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                IDLE: begin
                    if (flush_i) begin
                        state     <= SWEEP;
                        sweep_cnt <= '0;
                        busy_o    <= 1'b1;
                    end
                end
                default: begin
                    state  <= SWEEP;
                    busy_o <= 1'b1;
                end
            endcase
        end
    end

    assign idle = (state == IDLE);

    logic                  tag_we;
    logic                  stat_we;
    logic [INDEX_SIZE-1:0] wr_idx;
    logic [SW-1:0]         stat_wdata;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        tag_we     = 1'b0;
        stat_we    = 1'b0;
        wr_idx     = sweep_cnt;
        stat_wdata = pack_stat(1'b0, 1'b0);
        if (!rst_i) begin
            tag_we  = idle && port0_write_i;
            stat_we = !idle || port0_write_i;
            if (idle) begin
                wr_idx     = port0_index_i;
                stat_wdata = pack_stat(port0_valid_i, port0_dirty_i);
            end
        end
    end

    logic [TW-1:0] tag_mem  [WAYS][DEPTH];
    logic [SW-1:0] stat_mem [WAYS][DEPTH];

    // NOTE: the arrays have no reset so they map onto block RAM; the sweep provides the invalid state.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            if (stat_we && (!idle || port0_way_i == WAY_W'(w)))
                stat_mem[w][wr_idx] <= stat_wdata;
            if (tag_we && port0_way_i == WAY_W'(w))
                tag_mem[w][port0_index_i] <= pack_tag(port0_tag_i);
        end
    end

    logic                p0_rd;
    logic                p1_rd;
    logic [TW-1:0]       p0_tag_q;
    logic [SW-1:0]       p0_stat_q;
    logic [TW-1:0]       p1_tag_q  [WAYS];
    logic [SW-1:0]       p1_stat_q [WAYS];
    logic [TAG_SIZE-1:0] p1_cmp_q;

    assign p0_rd = idle && port0_read_i && !port0_write_i;
    assign p1_rd = idle && port1_read_i;

    // Read registers hold their contents until the next accepted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p0_tag_q  <= '0;
            p0_stat_q <= '0;
            p1_cmp_q  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                p1_tag_q[w]  <= '0;
                p1_stat_q[w] <= '0;
            end
        end else begin
            if (p0_rd) begin
                p0_tag_q  <= tag_mem[port0_way_i][port0_index_i];
                p0_stat_q <= stat_mem[port0_way_i][port0_index_i];
            end
            if (p1_rd) begin
                p1_cmp_q <= port1_tag_i;
                for (int w = 0; w < WAYS; w++) begin
                    p1_tag_q[w]  <= tag_mem[w][port1_index_i];
                    p1_stat_q[w] <= stat_mem[w][port1_index_i];
                end
            end
        end
    end

    assign port0_tag_o   = p0_tag_q[TAG_SIZE-1:0];
    assign port0_valid_o = p0_stat_q[1];
    assign port0_dirty_o = p0_stat_q[0];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             hit_dirty;
    logic             p1_err;

    // Scanning from the top way down lets the lowest matching way win.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        hit_dirty = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (p1_stat_q[w][1] && p1_tag_q[w][TAG_SIZE-1:0] == p1_cmp_q) begin
                hit       = 1'b1;
                hit_way   = WAY_W'(w);
                hit_dirty = p1_stat_q[w][0];
            end
        end
    end

`ifdef DATA_TAG_PARITY_EN
    logic p0_rd_q;
    logic p1_rd_q;
    logic p0_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p0_rd_q <= 1'b0;
            p1_rd_q <= 1'b0;
        end else begin
            p0_rd_q <= p0_rd;
            p1_rd_q <= p1_rd;
        end
    end

    always_comb begin
        p0_err = (^p0_tag_q) | (^p0_stat_q);
        p1_err = 1'b0;
        for (int w = 0; w < WAYS; w++)
            p1_err = p1_err | (^p1_tag_q[w]) | (^p1_stat_q[w]);
    end

    assign parity_error_o = (p0_rd_q && p0_err) || (p1_rd_q && p1_err);
`else
    assign p1_err = 1'b0;
`endif

    assign port1_hit_o     = hit && !p1_err;
    assign port1_hit_way_o = p1_err ? '0 : hit_way;
    assign port1_dirty_o   = hit_dirty && !p1_err;
endmodule

// File: tb/tb_data_tag_array.sv
// Directed self-checking bench for data_tag_array: sweep timing, port 0/1 behaviour, collisions, flush.
// Define DATA_TAG_PARITY_EN for both files to include the parity-error scenario.
module tb_data_tag_array;
    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        busy_o;
`ifdef DATA_TAG_PARITY_EN
    logic        parity_error_o;
`endif
    logic [6:0]  port0_index_i;
    logic [0:0]  port0_way_i;
    logic [19:0] port0_tag_i;
    logic        port0_valid_i;
    logic        port0_dirty_i;
    logic        port0_write_i;
    logic        port0_read_i;
    logic [19:0] port0_tag_o;
    logic        port0_valid_o;
    logic        port0_dirty_o;
    logic [6:0]  port1_index_i;
    logic [19:0] port1_tag_i;
    logic        port1_read_i;
    logic        port1_hit_o;
    logic [0:0]  port1_hit_way_o;
    logic        port1_dirty_o;

    int total = 0;
    int bad   = 0;
    int n;

    data_tag_array dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .busy_o          (busy_o),
`ifdef DATA_TAG_PARITY_EN
        .parity_error_o  (parity_error_o),
`endif
        .port0_index_i   (port0_index_i),
        .port0_way_i     (port0_way_i),
        .port0_tag_i     (port0_tag_i),
        .port0_valid_i   (port0_valid_i),
        .port0_dirty_i   (port0_dirty_i),
        .port0_write_i   (port0_write_i),
        .port0_read_i    (port0_read_i),
        .port0_tag_o     (port0_tag_o),
        .port0_valid_o   (port0_valid_o),
        .port0_dirty_o   (port0_dirty_o),
        .port1_index_i   (port1_index_i),
        .port1_tag_i     (port1_tag_i),
        .port1_read_i    (port1_read_i),
        .port1_hit_o     (port1_hit_o),
        .port1_hit_way_o (port1_hit_way_o),
        .port1_dirty_o   (port1_dirty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic p0_write(input logic [6:0] idx, input logic [0:0] way, input logic [19:0] tag,
                            input logic v, input logic d);
        port0_index_i = idx;
        port0_way_i   = way;
        port0_tag_i   = tag;
        port0_valid_i = v;
        port0_dirty_i = d;
        port0_write_i = 1'b1;
        step();
        port0_write_i = 1'b0;
    endtask

    task automatic p0_read(input logic [6:0] idx, input logic [0:0] way);
        port0_index_i = idx;
        port0_way_i   = way;
        port0_read_i  = 1'b1;
        step();
        port0_read_i  = 1'b0;
    endtask

    task automatic p1_lookup(input logic [6:0] idx, input logic [19:0] tag);
        port1_index_i = idx;
        port1_tag_i   = tag;
        port1_read_i  = 1'b1;
        step();
        port1_read_i  = 1'b0;
    endtask

    task automatic check_p1(input string name, input logic hit, input logic [0:0] way, input logic dirty);
        check({name, "_hit"}, port1_hit_o, hit);
        check({name, "_way"}, port1_hit_way_o, way);
        check({name, "_dirty"}, port1_dirty_o, dirty);
    endtask

    task automatic check_p0(input string name, input logic [19:0] tag, input logic v, input logic d);
        check({name, "_tag"}, port0_tag_o, tag);
        check({name, "_valid"}, port0_valid_o, v);
        check({name, "_dirty"}, port0_dirty_o, d);
    endtask

    task automatic wait_sweep(output int cycles);
        cycles = 0;
        while (busy_o === 1'b1 && cycles < 1000) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        port0_index_i = '0; port0_way_i = '0; port0_tag_i = '0;
        port0_valid_i = 1'b0; port0_dirty_i = 1'b0;
        port0_write_i = 1'b0; port0_read_i = 1'b0;
        port1_index_i = '0; port1_tag_i = '0; port1_read_i = 1'b0;

        // Reset state and initial sweep length.
        step();
        step();
        check("rst_busy", busy_o, 1'b1);
        check_p1("rst_p1", 1'b0, 1'b0, 1'b0);
        check_p0("rst_p0", 20'h0, 1'b0, 1'b0);
        rst_i = 1'b0;
        wait_sweep(n);
        check("sweep_len_reset", n, 128);
        p1_lookup(7'd0, 20'h00000);
        check("post_reset_miss0", port1_hit_o, 1'b0);
        p1_lookup(7'd127, 20'hFFFFF);
        check("post_reset_miss127", port1_hit_o, 1'b0);

        // Basic write then lookup and port 0 read-back.
        p0_write(7'd5, 1'b1, 20'h1ABCD, 1'b1, 1'b1);
        p1_lookup(7'd5, 20'h1ABCD);
        check_p1("lookup5", 1'b1, 1'b1, 1'b1);
        p0_read(7'd5, 1'b1);
        check_p0("read5", 20'h1ABCD, 1'b1, 1'b1);
        step();
        check("hold_p1_hit", port1_hit_o, 1'b1);
        check("hold_p0_tag", port0_tag_o, 20'h1ABCD);
        // Write wins over read: port 0 outputs keep the previous read data.
        port0_read_i = 1'b1;
        p0_write(7'd6, 1'b0, 20'h00333, 1'b1, 1'b0);
        port0_read_i = 1'b0;
        check_p0("write_prio", 20'h1ABCD, 1'b1, 1'b1);

        // Same-cycle write and lookup of set 9 returns the old contents.
        port1_index_i = 7'd9;
        port1_tag_i   = 20'h00042;
        port1_read_i  = 1'b1;
        p0_write(7'd9, 1'b0, 20'h00042, 1'b1, 1'b0);
        port1_read_i  = 1'b0;
        check("collide_miss", port1_hit_o, 1'b0);
        p1_lookup(7'd9, 20'h00042);
        check_p1("collide_rehit", 1'b1, 1'b0, 1'b0);
        p1_lookup(7'd9, 20'h00043);
        check_p1("tag_mismatch", 1'b0, 1'b0, 1'b0);

        // Fill sets 0..3, flush, and poke requests (and a second flush) mid-sweep.
        for (int i = 0; i < 4; i++)
            p0_write(7'(i), 1'b0, 20'h00100 + 20'(i), 1'b1, 1'b1);
        p1_lookup(7'd3, 20'h00103);
        check_p1("prefill_hit", 1'b1, 1'b0, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_busy", busy_o, 1'b1);
        n = 0;
        while (busy_o === 1'b1 && n < 1000) begin
            if (n == 10) begin
                flush_i = 1'b1;
                port0_index_i = 7'd5; port0_way_i = 1'b0; port0_tag_i = 20'h00555;
                port0_valid_i = 1'b1; port0_dirty_i = 1'b1; port0_write_i = 1'b1;
                port1_index_i = 7'd9; port1_tag_i = 20'h00042; port1_read_i = 1'b1;
            end else if (n == 11) begin
                flush_i = 1'b0; port0_write_i = 1'b0; port1_read_i = 1'b0;
                port0_index_i = 7'd0; port0_read_i = 1'b1;
            end else begin
                port0_read_i = 1'b0;
            end
            step();
            n++;
        end
        port0_read_i = 1'b0;
        check("sweep_len_flush", n, 128);
        check_p1("busy_p1_held", 1'b1, 1'b0, 1'b1);
        check("busy_p0_held", port0_tag_o, 20'h1ABCD);
        p0_read(7'd2, 1'b0);
        check_p0("flushed_set2", 20'h00102, 1'b0, 1'b0);
        p1_lookup(7'd5, 20'h00555);
        check("busy_write_ignored", port1_hit_o, 1'b0);
        p1_lookup(7'd1, 20'h00101);
        check("flushed_miss1", port1_hit_o, 1'b0);

        // Both ways match: the lowest way wins.
        p0_write(7'd3, 1'b0, 20'h00777, 1'b1, 1'b0);
        p0_write(7'd3, 1'b1, 20'h00777, 1'b1, 1'b1);
        p1_lookup(7'd3, 20'h00777);
        check_p1("dual_match", 1'b1, 1'b0, 1'b0);

        // Top set, all-ones tag.
        p0_write(7'd127, 1'b1, 20'hFFFFF, 1'b1, 1'b0);
        p1_lookup(7'd127, 20'hFFFFF);
        check_p1("set127", 1'b1, 1'b1, 1'b0);
        p0_read(7'd127, 1'b1);
        check_p0("read127", 20'hFFFFF, 1'b1, 1'b0);

        // Reset in the middle of a sweep restarts it from set 0.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 50; i++) step();
        rst_i = 1'b1;
        step();
        check("midrst_busy", busy_o, 1'b1);
        check("midrst_p0_tag", port0_tag_o, 20'h0);
        check("midrst_hit", port1_hit_o, 1'b0);
        rst_i = 1'b0;
        wait_sweep(n);
        check("sweep_len_midrst", n, 128);
        p1_lookup(7'd127, 20'hFFFFF);
        check("midrst_miss127", port1_hit_o, 1'b0);

`ifdef DATA_TAG_PARITY_EN
        p0_write(7'd2, 1'b0, 20'h00222, 1'b1, 1'b0);
        p1_lookup(7'd2, 20'h00222);
        check("par_clean_hit", port1_hit_o, 1'b1);
        check("par_clean_err", parity_error_o, 1'b0);
        dut.tag_mem[0][2][0] = ~dut.tag_mem[0][2][0];
        p1_lookup(7'd2, 20'h00222);
        check("par_err", parity_error_o, 1'b1);
        check("par_hit_forced", port1_hit_o, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
